// File: rtl/pht_update_scheduler.sv
// Port owner for one pattern-history counter table: reset sweep,
// pending-update FIFO, and lookup vs. read-modify-write arbitration.
module pht_update_scheduler #(
    parameter int         ENTRIES      = 1024,
    parameter int         INDEX_WIDTH  = 10,
    parameter int         QUEUE_DEPTH  = 4,
    parameter int         STARVE_LIMIT = 4,
    parameter logic [1:0] INIT_STATE   = 2'b01
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   upd_valid_i,
    output logic                   upd_ready_o,
    input  logic [INDEX_WIDTH-1:0] upd_index_i,
    input  logic                   upd_taken_i,
    input  logic                   lkp_valid_i,
    input  logic [INDEX_WIDTH-1:0] lkp_index_i,
    output logic                   lkp_gnt_o,
    output logic                   lkp_rvalid_o,
    output logic [1:0]             lkp_state_o,
    output logic                   lkp_taken_o,
    output logic                   tbl_en_o,
    output logic                   tbl_we_o,
    output logic [INDEX_WIDTH-1:0] tbl_addr_o,
    output logic [1:0]             tbl_wdata_o,
    input  logic [1:0]             tbl_rdata_i,
    output logic                   init_busy_o
);

    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(ENTRIES - 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    localparam logic [QW:0] DEPTH = (QW + 1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {INIT, IDLE, WR} state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] ptr;
    logic [SW-1:0]          starve;
    logic                   rvalid;

    logic [INDEX_WIDTH-1:0] q_index [QUEUE_DEPTH];
    logic                   q_taken [QUEUE_DEPTH];
    logic [QW-1:0]          head;
    logic [QW-1:0]          tail;
    logic [QW:0]            count;

    logic                   nonempty;
    logic                   full;
    logic                   forced;
    logic                   upd_rd;
    logic                   gnt;
    logic                   push;
    logic                   pop;
    logic [INDEX_WIDTH-1:0] head_index;
    logic                   head_taken;
    logic [1:0]             next_ctr;

    assign nonempty   = count != '0;
    assign full       = count == DEPTH;
    assign head_index = q_index[head];
    assign head_taken = q_taken[head];
    assign forced     = nonempty && starve == LIMIT;
    assign upd_rd     = state == IDLE && en_i && nonempty
                        && (forced || !lkp_valid_i);
    assign gnt        = state == IDLE && en_i && lkp_valid_i && !forced;
    assign pop        = state == WR;

    // Full blocks acceptance even when the head pops this cycle.
    assign upd_ready_o = !full && state != INIT && en_i;
    assign push        = upd_valid_i && upd_ready_o;

    assign lkp_gnt_o    = gnt;
    assign lkp_rvalid_o = rvalid;
    assign lkp_state_o  = rvalid ? tbl_rdata_i : 2'b00;
    assign lkp_taken_o  = lkp_state_o[1];
    assign init_busy_o  = state == INIT;

    // Saturating 2-bit counter step from the value read for the head entry.
    always_comb begin
        next_ctr = tbl_rdata_i;
        if (head_taken) begin
            if (tbl_rdata_i != 2'b11) next_ctr = tbl_rdata_i + 2'b01;
        end else begin
            if (tbl_rdata_i != 2'b00) next_ctr = tbl_rdata_i - 2'b01;
        end
    end

    // Table port mux; the sweep is held off while reset is asserted.
    always_comb begin
        tbl_en_o    = 1'b0;
        tbl_we_o    = 1'b0;
        tbl_addr_o  = head_index;
        tbl_wdata_o = next_ctr;
        unique case (state)
            INIT: begin
                tbl_en_o    = rst_ni;
                tbl_we_o    = rst_ni;
                tbl_addr_o  = ptr;
                tbl_wdata_o = INIT_STATE;
            end
            IDLE: begin
                tbl_en_o   = upd_rd || gnt;
                tbl_addr_o = gnt ? lkp_index_i : head_index;
            end
            WR: begin
                tbl_en_o = 1'b1;
                tbl_we_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Sweep / idle / write-back sequencing, starvation count, read-valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= INIT;
            ptr    <= '0;
            starve <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= gnt;
            unique case (state)
                INIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST) state <= IDLE;
                end
                IDLE: if (upd_rd) state <= WR;
                WR:   state <= IDLE;
                default: state <= INIT;
            endcase
            if (upd_rd) starve <= '0;
            else if (gnt && nonempty) starve <= starve + 1'b1;
            else if (!nonempty) starve <= '0;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // FIFO storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_index[tail] <= upd_index_i;
            q_taken[tail] <= upd_taken_i;
        end
    end

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Bench for pht_update_scheduler: table macro model plus a
// queue/array reference of the arbitration and counter rules.
module tb_pht_update_scheduler;

    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          upd_valid = 1'b0;
    logic          upd_taken = 1'b0;
    logic          lkp_valid = 1'b0;
    logic [IW-1:0] upd_index = '0;
    logic [IW-1:0] lkp_index = '0;
    logic          upd_ready, lkp_gnt, lkp_rvalid, lkp_taken;
    logic          tbl_en, tbl_we, init_busy;
    logic [1:0]    lkp_state, tbl_wdata;
    logic [1:0]    tbl_rdata = 2'b00;
    logic [IW-1:0] tbl_addr;
    logic [1:0]    mem [N];

    int errors = 0;
    int checks = 0;

    int q_idx[$];
    bit q_tk[$];
    int exp_tbl [N];
    int sweep_left = 0;
    int consec = 0;
    bit wr_due = 0;
    bit prev_gnt = 0;
    int prev_exp = 0;

    bit         s_gnt, s_rd, s_wr, s_push;
    logic [1:0] s_state;

    pht_update_scheduler #(
        .ENTRIES(N), .INDEX_WIDTH(IW), .QUEUE_DEPTH(4),
        .STARVE_LIMIT(4), .INIT_STATE(2'b01)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .upd_valid_i(upd_valid), .upd_ready_o(upd_ready),
        .upd_index_i(upd_index), .upd_taken_i(upd_taken),
        .lkp_valid_i(lkp_valid), .lkp_index_i(lkp_index),
        .lkp_gnt_o(lkp_gnt), .lkp_rvalid_o(lkp_rvalid),
        .lkp_state_o(lkp_state), .lkp_taken_o(lkp_taken),
        .tbl_en_o(tbl_en), .tbl_we_o(tbl_we), .tbl_addr_o(tbl_addr),
        .tbl_wdata_o(tbl_wdata), .tbl_rdata_i(tbl_rdata),
        .init_busy_o(init_busy)
    );

    always #5 clk = ~clk;

    // Sync-read single-port table macro.
    always @(posedge clk) begin
        if (tbl_en) begin
            if (tbl_we) mem[tbl_addr] <= tbl_wdata;
            else tbl_rdata <= mem[tbl_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input bit t);
        int n;
        n = t ? v + 1 : v - 1;
        if (n < 0) n = 0;
        if (n > 3) n = 3;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Predict this cycle's port use from the rules, compare, advance model.
    task automatic sample();
        int qs, e_addr, e_wd;
        bit e_init, e_en, e_we, e_gnt, e_rd, e_wr, e_ready;
        #1;
        qs = q_idx.size();
        e_init = sweep_left > 0;
        e_en = 0; e_we = 0; e_gnt = 0; e_rd = 0; e_wr = 0;
        e_addr = 0; e_wd = 0;
        if (e_init) begin
            e_en = 1; e_we = 1; e_addr = N - sweep_left; e_wd = 1;
        end else if (wr_due) begin
            e_wr = 1; e_en = 1; e_we = 1; e_addr = q_idx[0];
            e_wd = sat(exp_tbl[q_idx[0]], q_tk[0]);
        end else if (en && qs > 0 && (consec >= 4 || !lkp_valid)) begin
            e_rd = 1; e_en = 1; e_addr = q_idx[0];
        end else if (en && lkp_valid) begin
            e_gnt = 1; e_en = 1; e_addr = lkp_index;
        end
        e_ready = qs < 4 && !e_init && en;
        chk("init_busy", init_busy, e_init);
        chk("lkp_gnt", lkp_gnt, e_gnt);
        chk("tbl_en", tbl_en, e_en);
        if (e_en) begin
            chk("tbl_we", tbl_we, e_we);
            chk("tbl_addr", tbl_addr, e_addr);
            if (e_we) chk("tbl_wdata", tbl_wdata, e_wd);
        end
        chk("upd_ready", upd_ready, e_ready);
        chk("lkp_rvalid", lkp_rvalid, prev_gnt);
        chk("lkp_state", lkp_state, prev_gnt ? prev_exp : 0);
        chk("lkp_taken", lkp_taken, prev_gnt ? (prev_exp >> 1) : 0);
        s_state = lkp_state;
        s_gnt = lkp_gnt;
        s_rd = tbl_en && !tbl_we && !lkp_gnt;
        s_wr = tbl_en && tbl_we && !init_busy;
        s_push = upd_valid && upd_ready;
        prev_gnt = e_gnt;
        prev_exp = exp_tbl[lkp_index];
        if (e_init) sweep_left--;
        if (e_wr) begin
            exp_tbl[q_idx[0]] = e_wd;
            void'(q_idx.pop_front());
            void'(q_tk.pop_front());
        end
        wr_due = e_rd;
        if (e_rd) consec = 0;
        else if (e_gnt && qs > 0) consec++;
        else if (qs == 0) consec = 0;
        if (upd_valid && e_ready) begin
            q_idx.push_back(int'(upd_index));
            q_tk.push_back(upd_taken);
        end
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_init_busy", init_busy, 1);
        chk("rst_tbl_en", tbl_en, 0);
        chk("rst_gnt", lkp_gnt, 0);
        chk("rst_ready", upd_ready, 0);
        chk("rst_rvalid", lkp_rvalid, 0);
        tick();
        tick();
        q_idx.delete();
        q_tk.delete();
        for (int i = 0; i < N; i++) exp_tbl[i] = 1;
        sweep_left = N;
        consec = 0;
        wr_due = 0;
        prev_gnt = 0;
        rst_n = 1'b1;
    endtask

    task automatic lookup(input int idx, output logic [1:0] st);
        en = 1; upd_valid = 0; lkp_valid = 1;
        lkp_index = IW'(idx);
        sample();
        tick();
        lkp_valid = 0;
        sample();
        st = s_state;
        tick();
    endtask

    task automatic drain();
        en = 1; upd_valid = 0; lkp_valid = 0;
        for (int i = 0; i < 40; i++) begin
            if (q_idx.size() == 0 && !wr_due) break;
            step();
        end
        chk("drain_empty", q_idx.size(), 0);
    endtask

    task automatic push_one(input int idx, input bit tk, output int stall);
        upd_valid = 1; upd_index = IW'(idx); upd_taken = tk;
        stall = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (s_push) break;
            stall++;
            tick();
        end
        chk("push_accepted", s_push, 1);
        tick();
        upd_valid = 0;
    endtask

    initial begin
        logic [1:0] st;
        int g, stall;

        @(negedge clk);
        do_reset();

        // T1: sweep ignores requests; first lookup sees INIT_STATE.
        en = 1; upd_valid = 1; lkp_valid = 1;
        for (int i = 0; i < N; i++) step();
        upd_valid = 0; lkp_valid = 0;
        lookup(5, st);
        chk("t1_lookup5", st, 1);

        // T2: three taken updates on one index saturate at 3.
        for (int k = 0; k < 3; k++) begin
            push_one(3, 1, stall);
            chk("t2_no_stall", stall, 0);
        end
        drain();
        lookup(3, st);
        chk("t2_idx3", st, 3);

        // T5: three not-taken updates floor at 0.
        for (int k = 0; k < 3; k++) push_one(7, 0, stall);
        drain();
        lookup(7, st);
        chk("t5_idx7", st, 0);

        // T3: continuous lookups starve one update for four grants.
        en = 1; lkp_valid = 1; lkp_index = 2;
        upd_valid = 1; upd_index = 10; upd_taken = 1;
        step();
        upd_valid = 0;
        g = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (s_rd) break;
            if (s_gnt) g++;
            tick();
        end
        chk("t3_grants", g, 4);
        chk("t3_forced_rd", s_rd, 1);
        tick();
        sample();
        chk("t3_wr", s_wr, 1);
        tick();
        sample();
        chk("t3_resume", s_gnt, 1);
        tick();
        lkp_valid = 0;
        drain();

        // T4: fifth push waits until the head entry has popped.
        lkp_valid = 1; lkp_index = 1;
        for (int k = 0; k < 5; k++) begin
            push_one(11 + k, 1, stall);
            if (k < 4) chk("t4_first_four", stall, 0);
            else chk("t4_fifth_stall", stall, 3);
        end
        lkp_valid = 0;
        drain();
        lookup(15, st);
        chk("t4_idx15", st, 2);

        // Random traffic against the reference model.
        for (int c = 0; c < 800; c++) begin
            en = $urandom_range(0, 9) != 0;
            lkp_valid = $urandom_range(0, 1) == 1;
            lkp_index = IW'($urandom_range(0, N - 1));
            upd_valid = $urandom_range(0, 2) == 0;
            upd_index = IW'($urandom_range(0, N - 1));
            upd_taken = $urandom_range(0, 1) == 1;
            step();
        end
        drain();
        for (int i = 0; i < N; i++) begin
            lookup(i, st);
            chk("readback", st, exp_tbl[i]);
        end

        // T6: reset during a write-back with three entries still queued.
        lkp_valid = 1; lkp_index = 0;
        for (int k = 0; k < 4; k++) push_one(9, 1, stall);
        lkp_valid = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (s_wr) break;
            tick();
        end
        chk("t6_in_wr", s_wr, 1);
        chk("t6_queued", q_idx.size(), 3);
        do_reset();
        en = 1;
        for (int i = 0; i < N + 10; i++) step();
        lookup(9, st);
        chk("t6_idx9", st, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
